// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states, default width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Divide ops have bit 1 set.
  function automatic logic op_is_div(input logic [1:0] op_code);
    return op_code[1];
  endfunction

  // Signed ops have bit 0 clear.
  function automatic logic op_is_signed(input logic [1:0] op_code);
    return ~op_code[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 33-bit accumulator.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] sreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             div_mode_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] sreg_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply: conditional add then shift {acc,sreg} right.
  // Divide: shift {rem,quot} left, trial subtract, keep on non-negative.
  always_comb begin
    sum    = acc_i + {1'b0, opnd_i};
    rem_sh = {acc_i[WIDTH-1:0], sreg_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    acc_o  = acc_i;
    sreg_o = sreg_i;
    if (div_mode_i) begin
      if (!diff[WIDTH]) begin
        acc_o  = diff;
        sreg_o = {sreg_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o  = rem_sh;
        sreg_o = {sreg_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (sreg_i[0]) begin
        acc_o  = {1'b0, sum[WIDTH:1]};
        sreg_o = {sum[0], sreg_i[WIDTH-1:1]};
      end else begin
        acc_o  = {1'b0, acc_i[WIDTH:1]};
        sreg_o = {acc_i[0], sreg_i[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_sreg;
  logic [2*WIDTH-1:0] prod_mag;
  logic [WIDTH-1:0] rem_mag;

  assign signed_op = op_is_signed(op);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign prod_mag  = {acc_q[WIDTH-1:0], sreg_q};
  assign rem_mag   = acc_q[WIDTH-1:0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i      (acc_q),
    .sreg_i     (sreg_q),
    .opnd_i     (opnd_q),
    .div_mode_i (op_is_div(op_q)),
    .acc_o      (step_acc),
    .sreg_o     (step_sreg)
  );

  // Next-state logic: capture in IDLE, iterate in RUN, sign fix-up and write-back in FIX.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    sreg_d     = sreg_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op;
          neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_op & a[WIDTH-1];
          cnt_d     = '0;
          acc_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
          dz_d      = 1'b0;
          if (op_is_div(op)) begin
            opnd_d = b_mag;
            sreg_d = a_mag;
            if (b == '0) begin
              // Keep the raw dividend so it can be returned in hi untouched.
              dz_d    = 1'b1;
              sreg_d  = a;
              state_d = ST_FIX;
            end
          end else begin
            opnd_d = a_mag;
            sreg_d = b_mag;
          end
        end
      end
      ST_RUN: begin
        acc_d  = step_acc;
        sreg_d = step_sreg;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        div_zero_d = 1'b0;
        if (dz_q) begin
          hi_d       = sreg_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else if (op_is_div(op_q)) begin
          lo_d = neg_res_q ? -sreg_q : sreg_q;
          hi_d = neg_rem_q ? -rem_mag : rem_mag;
        end else begin
          {hi_d, lo_d} = neg_res_q ? -prod_mag : prod_mag;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A pipeline kill overrides everything and leaves results untouched.
    if (flush) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MULT;
      acc_q      <= '0;
      sreg_q     <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      sreg_q     <= sreg_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq with hand-computed expectations.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  logic busy_at_start;
  logic busy_at_done;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request (caller is #1 after a rising edge) and wait for done.
  task automatic run_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_at_start = busy;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    busy_at_done = busy;
    $display("[TB] op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d latency=%0d",
             op_v, a_v, b_v, hi, lo, div_zero, lat);
  endtask

  initial begin
    int saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MULTU 7*6
    run_op(2'b01, 32'd7, 32'd6);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy_start", 64'(busy_at_start), 64'd1);
    chk("multu_busy_done", 64'(busy_at_done), 64'd0);
    chk("multu_hi", 64'(hi), 64'd0);
    chk("multu_lo", 64'(lo), 64'd42);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);

    // Signed multiplies, issued back-to-back in each done cycle
    run_op(2'b00, 32'h8000_0000, 32'd2);
    chk("mult_neg_lat", 64'(lat), 64'd33);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_0000_0000);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mult_m1m1", {hi, lo}, 64'h0000_0000_0000_0001);

    // Divides
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_m7_2_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    chk("divu_lo", 64'(lo), 64'h7FFF_FFFC);
    chk("divu_hi", 64'(hi), 64'd1);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    chk("div_7_m2_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_7_m2_hi", 64'(hi), 64'd1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'd0);

    // Divide by zero
    run_op(2'b11, 32'd5, 32'd0);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_hi", 64'(hi), 64'd5);
    chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("dz_flag", 64'(div_zero), 64'd1);
    @(posedge clk);
    #1;
    chk("dz_held", 64'(div_zero), 64'd1);
    run_op(2'b01, 32'd3, 32'd5);
    chk("dz_clear", 64'(div_zero), 64'd0);
    chk("dz_clear_lo", 64'(lo), 64'd15);

    // Flush mid-multiply: no done, results unchanged
    @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    saw_done = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) saw_done++;
      @(posedge clk);
      #1;
    end
    chk("flush_no_done", 64'(saw_done), 64'd0);
    chk("flush_keep", {hi, lo}, 64'h0000_0000_0000_000F);
    run_op(2'b01, 32'd9, 32'd9);
    chk("after_flush_lat", 64'(lat), 64'd33);
    chk("after_flush_lo", 64'(lo), 64'd81);

    // Start pulsed while running must be ignored
    @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; a = 32'd11; b = 32'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (n == 4) begin
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
      end
      if (n == 5) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    $display("[TB] ignored-start run -> hi=%08h lo=%08h latency=%0d", hi, lo, lat);
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_result", {hi, lo}, 64'd143);
    @(posedge clk);
    #1;
    chk("ign_no_restart", 64'(busy), 64'd0);

    // Asynchronous reset mid-operation
    start = 1'b1; op = 2'b01; a = 32'hFFFF; b = 32'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_result", {hi, lo}, 64'd0);
    chk("arst_dz_done", {62'd0, div_zero, done}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_done = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) saw_done++;
      @(posedge clk);
      #1;
    end
    chk("arst_no_done", 64'(saw_done), 64'd0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("post_rst_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle multiply/divide sequencer attached beside the ALU in the execute stage. It accepts one MULT/MULTU/DIV/DIVU request and iterates a 33-bit add/subtract step 32 times (shift-add multiply, restoring divide). It then writes a 64-bit result into HI/LO registers. The pipeline stalls on `busy` and consumes results on `done`.

## Interface

Parameters
- `WIDTH`, 32: operand width; iteration count equals `WIDTH`.

Ports
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request strobe; sampled only in IDLE.
- `flush` in 1: abort the in-flight operation (pipeline kill).
- `op` in 2: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- `a` in WIDTH: multiplicand / dividend, sampled with `start`.
- `b` in WIDTH: multiplier / divisor, sampled with `start`.
- `busy` out 1: operation in flight; pipeline stall request.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi` out WIDTH: product high word / remainder.
- `lo` out WIDTH: product low word / quotient.
- `div_zero` out 1: the last completed divide had `b`==0; valid with `done` and held after it.

## Operation

- States: IDLE, RUN, FIX.
- IDLE, `start`=1, `flush`=0:
  - Capture `op`.
  - Capture operand magnitudes: two's-complement negate if signed op and MSB=1.
  - Record result-sign bits:
    - product sign = `a`[31]^`b`[31];
    - quotient sign = `a`[31]^`b`[31];
    - remainder sign = `a`[31].
  - Clear the 6-bit iteration counter.
  - Next state is RUN, or FIX if the op is a divide and `b`==0.
- RUN, multiply: if the multiplier LSB is 1, add the multiplicand into the upper accumulator (33-bit, carry kept). Then shift {acc, multiplier} right by 1.
- RUN, divide: shift {rem, quotient} left by 1. Trial-subtract the divisor from the 33-bit rem. If the result is non-negative, keep it and set quotient LSB=1; otherwise restore.
- RUN ends after `WIDTH` iterations (counter 0..31); next state is FIX.
- FIX:
  - Apply sign correction. MULT negates the 64-bit product. DIV negates the quotient and remainder per the recorded signs.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Divide by zero: `hi`=`a` unmodified, `lo`=32'hFFFFFFFF, `div_zero`=1. Any completed multiply or non-zero divide clears `div_zero`.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- 0x80000000 / -1 (signed) gives `lo`=0x80000000, `hi`=0. No trap or flag.
- `start` while not IDLE is ignored. No queuing.
- `flush` in any state: return to IDLE next edge. No `done`; `hi`/`lo`/`div_zero` unchanged.
- `flush`=1 with `start`=1 in IDLE: flush wins and the request is dropped.

## Timing

- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0; state IDLE, counter 0.
- `start` is sampled at edge k.
- `busy` is registered:
  - high after edge k;
  - low after the FIX edge, in the same cycle `done` is high.
- Normal latency:
  - RUN edges k+1..k+32;
  - FIX edge k+33;
  - `done`=1 during cycle k+33..k+34, i.e. 33 cycles after `start`.
- Divide by zero: FIX at edge k+1; `done` high for the cycle after edge k+1.
- `done` lasts exactly one cycle.
- A new `start` is accepted in the same cycle `done` is high, because the state is IDLE then.
- `rst_n` low mid-operation clears everything immediately. No `done` is produced.

## Structure

- Shared package `alu_pkg`:
  - op encoding constants (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`);
  - state encoding;
  - `WIDTH` default.
- One sub-module, `muldiv_step`: combinational 33-bit add/subtract plus shift for a single iteration. Inputs: acc, shift register, operand, mode. Outputs: next acc, next shift register. The parent holds the FSM, counter, sign fix-up and output registers.

## Test plan

- MULTU a=7, b=6, `start` at cycle 0 → `done` at cycle 33, `hi`=0, `lo`=42, `busy` high cycles 1–32.
- MULT a=0x80000000, b=2 → `hi`=0xFFFFFFFF, `lo`=0. MULT a=0xFFFFFFFF, b=0xFFFFFFFF → `hi`=0, `lo`=1.
- DIV a=-7 (0xFFFFFFF9), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=0xFFFFFFF9, b=2 → `lo`=0x7FFFFFFC, `hi`=1.
- DIVU a=5, b=0 → `done` 1 cycle after start, `hi`=5, `lo`=0xFFFFFFFF, `div_zero`=1. The following MULTU clears `div_zero`.
- MULTU started, then `flush` at cycle 10 → `busy` low at cycle 11, no `done`, `hi`/`lo` keep prior values. A new `start` at cycle 12 completes normally at cycle 45.
- `start` pulsed at cycle 5 during RUN with different operands → ignored; the result matches the original operands. `rst_n` low at cycle 20 → all outputs 0 immediately.
